// File: rtl/seg_scan_decoder.sv
// Recovers the digit values shown on a multiplexed, active-low 4-digit
// seven-segment bus by sampling settled scans and debouncing per digit.
module seg_scan_decoder #(
  parameter int SETTLE       = 4,
  parameter int STABLE_SCANS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic        upd,
  output logic        err
);

  localparam logic [7:0] SETTLE_M1  = 8'(SETTLE - 1);
  localparam logic [7:0] SETTLE_MAX = 8'(SETTLE);
  localparam logic [3:0] STABLE_MAX = 4'(STABLE_SCANS);

  // {legal, blank, value}; a blank pattern decodes to value 0
  function automatic logic [5:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b0000001: return {2'b10, 4'd0};
      7'b1001111: return {2'b10, 4'd1};
      7'b0010010: return {2'b10, 4'd2};
      7'b0000110: return {2'b10, 4'd3};
      7'b1001100: return {2'b10, 4'd4};
      7'b0100100: return {2'b10, 4'd5};
      7'b0100000: return {2'b10, 4'd6};
      7'b0001111: return {2'b10, 4'd7};
      7'b0000000: return {2'b10, 4'd8};
      7'b0000100: return {2'b10, 4'd9};
      7'b1111111: return {2'b11, 4'd0};
      default:    return 6'b000000;
    endcase
  endfunction

  // {exactly one digit selected, digit index}
  function automatic logic [2:0] an_select(input logic [3:0] a);
    case (a)
      4'b1110: return 3'b100;
      4'b1101: return 3'b101;
      4'b1011: return 3'b110;
      4'b0111: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c >= STABLE_MAX) ? STABLE_MAX : c + 4'd1;
  endfunction

  logic [3:0] an_p0;
  logic [7:0] cnt_p0;
  logic [3:0] cand_val [4];
  logic       cand_blk [4];
  logic [3:0] mcnt     [4];

  logic       vld_p0;
  logic [2:0] sel;
  logic [1:0] idx;
  logic [5:0] dec;
  logic       same;
  logic [3:0] nxt_cnt;
  logic       commit;
  logic       bad;

  // Stage p0: settled-sample decision and per-digit debounce evaluation
  always_comb begin
    vld_p0  = (cnt_p0 == SETTLE_M1) && (an == an_p0) && (an_p0 != 4'b1111);
    sel     = an_select(an_p0);
    idx     = sel[1:0];
    dec     = seg_decode(seg);
    same    = (cand_blk[idx] == dec[4]) && (cand_val[idx] == dec[3:0]);
    nxt_cnt = same ? sat_inc(mcnt[idx]) : 4'd1;
    commit  = vld_p0 && sel[2] && dec[5] && (nxt_cnt == STABLE_MAX);
    bad     = vld_p0 && !(sel[2] && dec[5]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_p0  <= 4'b1111;
      cnt_p0 <= 8'd0;
      digits <= 16'd0;
      blank  <= 4'b1111;
      upd    <= 1'b0;
      err    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cand_val[i] <= 4'd0;
        cand_blk[i] <= 1'b1;
        mcnt[i]     <= 4'd0;
      end
    end else begin
      an_p0 <= an;
      if (an != an_p0)
        cnt_p0 <= 8'd0;
      else if (cnt_p0 < SETTLE_MAX)
        cnt_p0 <= cnt_p0 + 8'd1;
      err <= bad;
      upd <= 1'b0;
      if (vld_p0 && sel[2]) begin
        if (!dec[5]) begin
          mcnt[idx] <= 4'd0;
        end else begin
          cand_val[idx] <= dec[3:0];
          cand_blk[idx] <= dec[4];
          mcnt[idx]     <= nxt_cnt;
        end
      end
      // Stage p1: committed outputs, upd only on an actual change
      if (commit) begin
        digits[{idx, 2'b00} +: 4] <= dec[3:0];
        blank[idx]                <= dec[4];
        upd <= (digits[{idx, 2'b00} +: 4] != dec[3:0]) || (blank[idx] != dec[4]);
      end
    end
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE, default 4: cycles an must hold one value before seg is sampled (legal range 1..255).
REQ-002 SHALL have parameter STABLE_SCANS, default 2: consecutive identical legal samples of a digit needed before commit (legal range 1..15).
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port an, input, 4: active-low digit enables; an[i]=0 selects digit i.
REQ-006 SHALL have port seg, input, 7: active-low segments; seg[6]=a, seg[5]=b, seg[4]=c, seg[3]=d, seg[2]=e, seg[1]=f, seg[0]=g.
REQ-007 SHALL have port digits, output, 16: committed values; digits[4i+3:4i] is digit i.
REQ-008 SHALL have port blank, output, 4: blank[i]=1 when digit i's committed pattern is all segments off.
REQ-009 SHALL have port upd, output, 1: one-cycle pulse when any digit/blank bit changes.
REQ-010 SHALL have port err, output, 1: one-cycle pulse on an illegal sample.

Function
REQ-011 SHALL register an each cycle; a settle counter clears to 0 whenever an differs from its previous-cycle value, else increments, saturating at SETTLE.
REQ-012 SHALL take exactly one sample per an dwell, in the cycle the counter first equals SETTLE-1; no further sample until an changes.
REQ-013 SHALL take no sample and raise no err when an=4'b1111.
REQ-014 SHALL treat an with two or more low bits at the sample point as illegal: err pulse; no digit state changes.
REQ-015 SHALL decode seg (a..g, active-low) as: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, blank=1111111.
REQ-016 SHALL treat any other seg pattern as illegal: err pulse, match count of the selected digit cleared to 0, committed outputs unchanged.
REQ-017 SHALL keep, per digit, a candidate (value + blank flag) and a 4-bit match count; a legal sample equal to the candidate increments the count (saturating at STABLE_SCANS); a differing legal sample loads the new candidate and sets the count to 1.
REQ-018 SHALL commit the candidate to digits/blank in the cycle after the sample that brings the count to STABLE_SCANS; with STABLE_SCANS=1 every legal sample commits.
REQ-019 SHALL pulse upd in the commit cycle only if the committed value or blank flag differs from the prior output; re-committing an identical value gives no upd.
REQ-020 SHALL drive digits to 0 for a blank commit.
REQ-021 SHALL make err and upd mutually exclusive per cycle; total latency sample->upd/err is 1 cycle.
REQ-022 SHALL handle digits independently; samples of digit j never affect digit i's candidate or count.

Reset
REQ-023 SHALL on rst=1 at a clock edge set digits=0, blank=4'b1111, upd=0, err=0, all candidates blank, all match counts 0, settle counter 0, registered an=4'b1111.
REQ-024 SHALL discard any sample in progress when rst asserts mid-dwell; after release a full SETTLE dwell is required before the next sample.

Verification
REQ-025 Defaults; an=1110, seg=0010010 held 10 cycles, then an=1111 for 4, then an=1110 seg=0010010 10 cycles -> digits[3:0]=2, blank[0]=0, single upd one cycle after the second sample; no err.
REQ-026 an=1101, seg=0110110 (illegal) held 8 cycles -> exactly one err pulse at cycle SETTLE (sample at SETTLE-1); digits and blank unchanged; upd=0.
REQ-027 an=1100, seg=0000001 -> one err pulse; no update of digit 0 or digit 1.
REQ-028 Digit 3 alternates 7 and 8 across four dwells -> no commit (count never reaches 2); then two dwells of 8 -> digits[15:12]=8, one upd.
REQ-029 an toggling every 2 cycles (shorter than SETTLE) with legal seg -> no samples, no upd, no err.
REQ-030 rst pulsed at settle count 2 of a dwell showing 5 -> all outputs return to reset values; no sample until SETTLE cycles after release.
